// File: rtl/neo_capture_axil_regs.sv
// neo_capture_axil_regs
//   AXI4-Lite slave exposing four 32-bit read/write registers at byte
//   offsets 0x0, 0x4, 0x8, 0xC (index = address bits [3:2]). The register
//   file is also presented flat on reg_o, and every completed write raises
//   a one-cycle strobe on reg_wr_pulse_o for the register it touched.
//
// Ports
//   S_AXI_ACLK / S_AXI_ARESETN   clock (rising edge), async active-low reset
//   S_AXI_AW* / S_AXI_W* / S_AXI_B*   write address, data, response channels
//   S_AXI_AR* / S_AXI_R*              read address and data channels
//   reg_o           {reg3, reg2, reg1, reg0}, reg0 in bits 31:0
//   reg_wr_pulse_o  bit n pulses for one cycle when register n is written
//
// Build option
//   NEO_CAPTURE_AXIL_WSTRB_EN  when defined, only byte lanes with their WSTRB
//                              bit set are written; otherwise WSTRB is ignored
//                              and the whole word is written.
//
// Write and read paths are independent FSMs. A read that samples a register
// on the same edge a write commits to it returns the pre-write value.

module neo_capture_axil_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic [4*C_S_AXI_DATA_WIDTH-1:0]   reg_o,
    output logic [3:0]                        reg_wr_pulse_o
);

    localparam int DW     = C_S_AXI_DATA_WIDTH;
    localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;

    typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} wstate_t;
    typedef enum logic       {R_IDLE, R_DATA}                      rstate_t;

    wstate_t           wstate, wstate_nxt;
    rstate_t           rstate, rstate_nxt;
    logic [3:0][DW-1:0] regs;

    // Held low through reset and set on the first edge after release, so
    // the ready outputs stay 0 during reset and rise on that first edge.
    logic rdy_en;

    logic [1:0]    aw_idx_q;
    logic [DW-1:0] wdata_q;
    logic          aw_hs, w_hs, ar_hs;
    logic          wr_commit;
    logic [1:0]    wr_idx;
    logic [DW-1:0] wr_data;

`ifdef NEO_CAPTURE_AXIL_WSTRB_EN
    logic [STRB_W-1:0] wstrb_q;
    logic [STRB_W-1:0] wr_strb;
`endif

    // Address low bits, protection bits and (without the strobe build)
    // WSTRB carry no meaning here.
    logic unused_ok;
    assign unused_ok = ^{S_AXI_AWADDR, S_AXI_ARADDR, S_AXI_AWPROT,
                         S_AXI_ARPROT, S_AXI_WSTRB};

    // Handshakes are derived from state directly (not from the ready
    // outputs) to keep the next-state logic free of combinational loops.
    assign aw_hs = S_AXI_AWVALID && rdy_en && (wstate == W_IDLE || wstate == W_HAVE_W);
    assign w_hs  = S_AXI_WVALID  && rdy_en && (wstate == W_IDLE || wstate == W_HAVE_AW);
    assign ar_hs = S_AXI_ARVALID && rdy_en && (rstate == R_IDLE);

    // Whichever half arrives this cycle is taken live; the other half
    // comes from the latch filled on its earlier handshake.
    assign wr_idx  = aw_hs ? S_AXI_AWADDR[3:2] : aw_idx_q;
    assign wr_data = w_hs  ? S_AXI_WDATA       : wdata_q;
`ifdef NEO_CAPTURE_AXIL_WSTRB_EN
    assign wr_strb = w_hs  ? S_AXI_WSTRB       : wstrb_q;
`endif

    // ---------------- write FSM ----------------
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            wstate <= W_IDLE;
            rdy_en <= 1'b0;
        end else begin
            wstate <= wstate_nxt;
            rdy_en <= 1'b1;
        end
    end

    always_comb begin
        wstate_nxt    = wstate;
        S_AXI_AWREADY = 1'b0;
        S_AXI_WREADY  = 1'b0;
        S_AXI_BVALID  = 1'b0;
        wr_commit     = 1'b0;
        case (wstate)
            W_IDLE: begin
                S_AXI_AWREADY = rdy_en;
                S_AXI_WREADY  = rdy_en;
                if (aw_hs && w_hs) begin
                    wstate_nxt = W_RESP;
                    wr_commit  = 1'b1;
                end else if (aw_hs) begin
                    wstate_nxt = W_HAVE_AW;
                end else if (w_hs) begin
                    wstate_nxt = W_HAVE_W;
                end
            end
            W_HAVE_AW: begin
                S_AXI_WREADY = rdy_en;
                if (w_hs) begin
                    wstate_nxt = W_RESP;
                    wr_commit  = 1'b1;
                end
            end
            W_HAVE_W: begin
                S_AXI_AWREADY = rdy_en;
                if (aw_hs) begin
                    wstate_nxt = W_RESP;
                    wr_commit  = 1'b1;
                end
            end
            W_RESP: begin
                S_AXI_BVALID = 1'b1;
                if (S_AXI_BREADY) wstate_nxt = W_IDLE;
            end
            default: wstate_nxt = W_IDLE;
        endcase
    end

    assign S_AXI_BRESP = 2'b00;

    // ---------------- write datapath ----------------
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            aw_idx_q       <= '0;
            wdata_q        <= '0;
`ifdef NEO_CAPTURE_AXIL_WSTRB_EN
            wstrb_q        <= '0;
`endif
            regs           <= '0;
            reg_wr_pulse_o <= '0;
        end else begin
            if (aw_hs) aw_idx_q <= S_AXI_AWADDR[3:2];
            if (w_hs) begin
                wdata_q <= S_AXI_WDATA;
`ifdef NEO_CAPTURE_AXIL_WSTRB_EN
                wstrb_q <= S_AXI_WSTRB;
`endif
            end
            if (wr_commit) begin
`ifdef NEO_CAPTURE_AXIL_WSTRB_EN
                for (int b = 0; b < STRB_W; b++)
                    if (wr_strb[b]) regs[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
`else
                regs[wr_idx] <= wr_data;
`endif
            end
            reg_wr_pulse_o <= wr_commit ? (4'b0001 << wr_idx) : 4'b0000;
        end
    end

    assign reg_o = regs;

    // ---------------- read FSM ----------------
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) rstate <= R_IDLE;
        else                rstate <= rstate_nxt;
    end

    always_comb begin
        rstate_nxt    = rstate;
        S_AXI_ARREADY = 1'b0;
        S_AXI_RVALID  = 1'b0;
        case (rstate)
            R_IDLE: begin
                S_AXI_ARREADY = rdy_en;
                if (ar_hs) rstate_nxt = R_DATA;
            end
            R_DATA: begin
                S_AXI_RVALID = 1'b1;
                if (S_AXI_RREADY) rstate_nxt = R_IDLE;
            end
            default: rstate_nxt = R_IDLE;
        endcase
    end

    // RDATA samples the register array before any same-edge write lands.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN)  S_AXI_RDATA <= '0;
        else if (ar_hs)      S_AXI_RDATA <= regs[S_AXI_ARADDR[3:2]];
    end

    assign S_AXI_RRESP = 2'b00;

endmodule

// File: tb/tb_neo_capture_axil_regs.sv
// Bench for neo_capture_axil_regs: directed AXI4-Lite traffic with a
// scoreboard. Tasks push expected read data, write responses and write
// pulses into queues; monitors pop and compare when the DUT presents them.
module tb_neo_capture_axil_regs;

    logic         clk, rst_n;
    logic [3:0]   awaddr, araddr;
    logic [2:0]   awprot, arprot;
    logic         awvalid, awready, wvalid, wready, bvalid, bready;
    logic         arvalid, arready, rvalid, rready;
    logic [31:0]  wdata, rdata;
    logic [3:0]   wstrb, pulse;
    logic [1:0]   bresp, rresp;
    logic [127:0] reg_o;

    int errors = 0;
    int checks = 0;

    logic [31:0] rd_q[$];
    logic [1:0]  b_q[$];
    logic [3:0]  pulse_q[$];

    neo_capture_axil_regs dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid),
        .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid),
        .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid),
        .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid),
        .S_AXI_RREADY(rready),
        .reg_o(reg_o), .reg_wr_pulse_o(pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (rst_n && rvalid && rready) begin
            if (rd_q.size() == 0) chk("r_unexpected", rvalid, 1'b0);
            else begin
                chk("rdata", rdata, rd_q.pop_front());
                chk("rresp", rresp, 2'b00);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && bvalid && bready) begin
            if (b_q.size() == 0) chk("b_unexpected", bvalid, 1'b0);
            else                 chk("bresp", bresp, b_q.pop_front());
        end
    end

    always @(negedge clk) begin
        if (pulse != 4'b0000) begin
            if (pulse_q.size() == 0) chk("pulse_unexpected", pulse, 4'b0000);
            else                     chk("wr_pulse", pulse, pulse_q.pop_front());
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        logic aw_now, w_now;
        logic [3:0] one = 4'b0001;
        pulse_q.push_back(one << a[3:2]);
        b_q.push_back(2'b00);
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1;
        for (int n = 0; n < 50 && (awvalid || wvalid); n++) begin
            @(negedge clk);
            aw_now = awvalid && awready;
            w_now  = wvalid && wready;
            @(posedge clk); #1;
            if (aw_now) awvalid = 1'b0;
            if (w_now)  wvalid  = 1'b0;
        end
        chk("wr_timeout", {awvalid, wvalid}, 2'b00);
        awvalid = 1'b0; wvalid = 1'b0;
    endtask

    task automatic read_issue(input logic [3:0] a, input logic [31:0] exp);
        logic hs;
        rd_q.push_back(exp);
        araddr = a; arvalid = 1'b1;
        for (int n = 0; n < 50 && arvalid; n++) begin
            @(negedge clk);
            hs = arready;
            @(posedge clk); #1;
            if (hs) arvalid = 1'b0;
        end
        chk("ar_timeout", arvalid, 1'b0);
        arvalid = 1'b0;
    endtask

    task automatic read_wait();
        logic hs = 1'b0;
        for (int n = 0; n < 50 && !hs; n++) begin
            @(negedge clk);
            hs = rvalid && rready;
            @(posedge clk); #1;
        end
        chk("r_timeout", hs, 1'b1);
    endtask

    task automatic axi_read(input logic [3:0] a, input logic [31:0] exp);
        read_issue(a, exp);
        read_wait();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1;
        awaddr = '0; awprot = '0; awvalid = 1'b0;
        wdata = '0; wstrb = 4'hF; wvalid = 1'b0; bready = 1'b1;
        araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b1;

        // -------- reset state --------
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_awready", awready, 1'b0);
        chk("rst_wready",  wready,  1'b0);
        chk("rst_arready", arready, 1'b0);
        chk("rst_bvalid",  bvalid,  1'b0);
        chk("rst_rvalid",  rvalid,  1'b0);
        chk("rst_rdata",   rdata,   32'h0);
        chk("rst_reg_o",   reg_o,   128'h0);
        chk("rst_pulse",   pulse,   4'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_awready_before_edge", awready, 1'b0);
        @(posedge clk); #1;
        chk("rel_awready", awready, 1'b1);
        chk("rel_wready",  wready,  1'b1);
        chk("rel_arready", arready, 1'b1);

        // -------- basic write/read of all four registers --------
        axi_write(4'h0, 32'h1, 4'hF);
        axi_write(4'h4, 32'h2, 4'hF);
        axi_write(4'h8, 32'h3, 4'hF);
        axi_write(4'hC, 32'h4, 4'hF);
        axi_read(4'h0, 32'h1);
        axi_read(4'h4, 32'h2);
        axi_read(4'h8, 32'h3);
        axi_read(4'hC, 32'h4);
        chk("reg_o_all", reg_o, 128'h00000004_00000003_00000002_00000001);
        // low address bits ignored
        axi_read(4'h7, 32'h2);

        // -------- W three cycles before AW --------
        pulse_q.push_back(4'b0100);
        b_q.push_back(2'b00);
        wdata = 32'hA5A5A5A5; wstrb = 4'hF; wvalid = 1'b1;
        @(posedge clk); #1;
        wvalid = 1'b0;
        chk("w_first_wready", wready,  1'b0);
        chk("w_first_awready", awready, 1'b1);
        chk("w_first_bvalid", bvalid,  1'b0);
        chk("w_first_reg2_old", reg_o[95:64], 32'h3);
        repeat (2) @(posedge clk);
        #1;
        awaddr = 4'h8; awvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0;
        chk("aw_late_reg2",   reg_o[95:64], 32'hA5A5A5A5);
        chk("aw_late_pulse",  pulse,  4'b0100);
        chk("aw_late_bvalid", bvalid, 1'b1);
        @(posedge clk); #1;
        chk("pulse_one_cycle", pulse, 4'b0000);

        // -------- BREADY stall blocks the next write --------
        bready = 1'b0;
        axi_write(4'h8, 32'h33, 4'hF);
        awaddr = 4'hC; wdata = 32'h77; awvalid = 1'b1; wvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_bvalid",  bvalid,  1'b1);
            chk("stall_awready", awready, 1'b0);
            chk("stall_wready",  wready,  1'b0);
        end
        chk("stall_reg3", reg_o[127:96], 32'h4);
        @(posedge clk); #1;
        bready = 1'b1;
        axi_write(4'hC, 32'h77, 4'hF);
        chk("after_stall_reg3", reg_o[127:96], 32'h77);
        chk("after_stall_reg2", reg_o[95:64],  32'h33);

        // -------- byte strobes --------
        axi_write(4'h4, 32'hFFFFFFFF, 4'hF);
        axi_write(4'h4, 32'h00000000, 4'b0010);
`ifdef NEO_CAPTURE_AXIL_WSTRB_EN
        axi_read(4'h4, 32'hFFFF00FF);
`else
        axi_read(4'h4, 32'h00000000);
`endif

        // -------- RREADY stall while the read register is rewritten --------
        rready = 1'b0;
        read_issue(4'h0, 32'h1);
        axi_write(4'h0, 32'h55, 4'hF);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rhold_rdata",  rdata,  32'h1);
            chk("rhold_rvalid", rvalid, 1'b1);
        end
        @(posedge clk); #1;
        rready = 1'b1;
        read_wait();
        axi_read(4'h0, 32'h55);

        // -------- read and write of the same register on the same edge --------
        fork
            axi_write(4'h0, 32'h66, 4'hF);
            axi_read(4'h0, 32'h55);
        join
        axi_read(4'h0, 32'h66);

        // -------- reset between AW and W --------
        awaddr = 4'h4; awvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0;
        chk("mid_awready", awready, 1'b0);
        chk("mid_wready",  wready,  1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_awready", awready, 1'b0);
        chk("async_wready",  wready,  1'b0);
        chk("async_arready", arready, 1'b0);
        chk("async_bvalid",  bvalid,  1'b0);
        chk("async_reg_o",   reg_o,   128'h0);
        chk("async_rdata",   rdata,   32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_bvalid", bvalid, 1'b0);
        axi_read(4'h0, 32'h0);
        axi_read(4'h4, 32'h0);
        axi_read(4'h8, 32'h0);
        axi_read(4'hC, 32'h0);

        repeat (3) @(posedge clk);
        #1;
        chk("rd_q_drained",    rd_q.size(),    0);
        chk("b_q_drained",     b_q.size(),     0);
        chk("pulse_q_drained", pulse_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/neo_capture_axil_regs.md
NEO_CAPTURE_AXIL_REGS -- requirements
Module: neo_capture_axil_regs

Interface
REQ-001 The block SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, meaning AXI4-Lite data width (only 32 supported).
REQ-002 The block SHALL have parameter C_S_AXI_ADDR_WIDTH, default 4, meaning byte address width covering four 32-bit registers at offsets 0x0, 0x4, 0x8, 0xC.
REQ-003 The block SHALL have these ports, one per line (name  direction  width  meaning):
- S_AXI_ACLK  in  1  sole clock, rising edge.
- S_AXI_ARESETN  in  1  reset, asynchronous, active-low.
- S_AXI_AWADDR / S_AXI_AWPROT / S_AXI_AWVALID  in  4/3/1  write address channel; AWPROT ignored.
- S_AXI_AWREADY  out  1  write address ready.
- S_AXI_WDATA / S_AXI_WSTRB / S_AXI_WVALID  in  32/4/1  write data channel.
- S_AXI_WREADY  out  1  write data ready.
- S_AXI_BRESP / S_AXI_BVALID  out  2/1  write response.
- S_AXI_BREADY  in  1  write response ready.
- S_AXI_ARADDR / S_AXI_ARPROT / S_AXI_ARVALID  in  4/3/1  read address channel; ARPROT ignored.
- S_AXI_ARREADY  out  1  read address ready.
- S_AXI_RDATA / S_AXI_RRESP / S_AXI_RVALID  out  32/2/1  read data channel.
- S_AXI_RREADY  in  1  read data ready.
- reg_o  out  128  registers 3..0 concatenated, reg0 in bits 31:0.
- reg_wr_pulse_o  out  4  one-cycle pulse per register written, bit n = register n.

Function
REQ-004 Register index SHALL be address bits [3:2]; bits [1:0] SHALL be ignored; all four registers read/write.
REQ-005 Write path SHALL be an FSM with states W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP.
REQ-006 In W_IDLE, AWREADY and WREADY SHALL both be 1; AW-only handshake -> W_HAVE_AW (AWREADY=0, address latched); W-only handshake -> W_HAVE_W (WREADY=0, data/strobe latched); both in same cycle -> W_RESP.
REQ-007 W_HAVE_AW SHALL wait for W handshake, W_HAVE_W for AW handshake, then go to W_RESP.
REQ-008 The register update, the reg_wr_pulse_o bit and BVALID=1 SHALL all take effect on the clock edge completing the last of the AW/W handshakes (zero added latency).
REQ-009 In W_RESP, AWREADY=WREADY=0 and BVALID=1 SHALL hold until BREADY=1, then return to W_IDLE; at most one write outstanding.
REQ-010 Read path SHALL have states R_IDLE (ARREADY=1, RVALID=0) and R_DATA (ARREADY=0, RVALID=1).
REQ-011 On AR handshake the addressed register SHALL be loaded into RDATA at that edge, entering R_DATA; RDATA SHALL remain stable until RREADY=1, then return to R_IDLE.
REQ-012 Read and write paths SHALL be independent; when a read samples the register being written on the same edge, RDATA SHALL return the pre-write value.
REQ-013 BRESP and RRESP SHALL always be 2'b00 (OKAY).
REQ-014 reg_wr_pulse_o SHALL be high for exactly one cycle per completed write and 0 otherwise.

Reset
REQ-015 While S_AXI_ARESETN=0 (asynchronous assertion): both FSMs in idle, AWREADY=WREADY=ARREADY=0, BVALID=RVALID=0, RDATA=0, all registers 0, reg_wr_pulse_o=0.
REQ-016 Ready signals SHALL rise on the first rising edge after reset deasserts; reset mid-transaction SHALL abandon it without a response or register update.

Configuration
REQ-017 With macro NEO_CAPTURE_AXIL_WSTRB_EN defined, only byte lanes with WSTRB bit set SHALL update; without it, WSTRB SHALL be ignored and all 32 bits written.

Verification
REQ-018 Bench SHALL cover: writes 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC, then reads -> RDATA 0x1,0x2,0x3,0x4, all RRESP=0, reg_o=0x00000004_00000003_00000002_00000001.
REQ-019 Bench SHALL cover: W (0xA5A5A5A5) presented 3 cycles before AW (0x8) -> WREADY low after W handshake, reg2=0xA5A5A5A5 and reg_wr_pulse_o=4'b0100 on AW edge, BVALID same edge.
REQ-020 Bench SHALL cover: BREADY held low 5 cycles after write -> BVALID stays 1, AWREADY/WREADY stay 0, second write stalls until B handshake.
REQ-021 Bench SHALL cover: write 0xFFFFFFFF to 0x4 then write 0x00000000 with WSTRB=4'b0010 -> read 0xFFFF00FF with NEO_CAPTURE_AXIL_WSTRB_EN, 0x00000000 without.
REQ-022 Bench SHALL cover: RREADY low 4 cycles after read of 0x0 while a write of 0x55 to 0x0 completes -> RDATA stays the pre-write value, next read returns 0x55.
REQ-023 Bench SHALL cover: ARESETN pulsed low mid-write (after AW, before W) -> no BVALID, registers read 0 after reset.
